// File: rtl/stack_pkg.sv
// Shared definitions for the stack reverser: FSM encodings
// and the level counter width.
package stack_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int lvl_w(input int length);
    return $clog2(length + 1);
  endfunction

endpackage

// File: rtl/stack_reverser.sv
// Frame reverser driving an external LIFO; frames larger than the stack split at capacity.
// Optional level_o port enabled by STACK_REVERSER_LEVEL_EN.
module stack_reverser
  import stack_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  input  logic             out_ready_i,
  output logic             stk_push_o,
  output logic             stk_pop_o,
  output logic [WIDTH-1:0] stk_data_o,
  input  logic [WIDTH-1:0] stk_data_i,
  input  logic             stk_full_i,
  input  logic             stk_empty_i,
  output logic             overflow_o
`ifdef STACK_REVERSER_LEVEL_EN
  ,
  output logic [$clog2(LENGTH+1)-1:0] level_o
`endif
);

  localparam int LW = lvl_w(LENGTH);

  state_t        state;
  logic [LW-1:0] level;
  logic          push;
  logic          pop;
  logic          lvl_one;

  assign in_ready_o = (state == FILL) & ~stk_full_i;
  assign push       = in_valid_i & in_ready_o;
  assign pop        = (state == DRAIN) & ~stk_empty_i
                    & (~out_valid_o | out_ready_i);
  assign lvl_one    = (level == LW'(1));

  assign stk_push_o = push;
  assign stk_pop_o  = pop;
  assign stk_data_o = in_data_i;

`ifdef STACK_REVERSER_LEVEL_EN
  assign level_o = level;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      level       <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      unique case (state)
        FILL: begin
          if (stk_full_i) begin
            state      <= DRAIN;
            overflow_o <= 1'b1;
          end else if (push && in_last_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && lvl_one)
            state <= FILL;
        end
        default: state <= FILL;
      endcase

      if (push)
        level <= level + LW'(1);
      else if (pop)
        level <= level - LW'(1);

      // The pop cycle loads the output register; otherwise a taken beat clears it.
      if (pop) begin
        out_valid_o <= 1'b1;
        out_data_o  <= stk_data_i;
        out_last_o  <= lvl_one;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule
